// File: rtl/wb_sad_minmax_finder_if.sv
// Bundle between the MEM/WB register, the min/max finder and the register file.
interface wb_sad_minmax_finder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              allow_find_in;
    logic              small_big_find_in;
    logic [ADDR_W-1:0] RdAddress_in;
    logic [DATA_W-1:0] sadResult_wire_1_in;
    logic [DATA_W-1:0] sadResult_wire_2_in;
    logic [DATA_W-1:0] sadResult_wire_3_in;
    logic [DATA_W-1:0] sadResult_wire_4_in;
    logic [DATA_W-1:0] sadResult_wire_5_in;
    logic [DATA_W-1:0] sadResult_wire_6_in;
    logic [DATA_W-1:0] sadResult_wire_7_in;
    logic [DATA_W-1:0] sadResult_wire_8_in;
    logic              busy_out;
    logic              stall_out;
    logic              done_out;
    logic [DATA_W-1:0] best_value_out;
    logic [2:0]        best_index_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;

    modport master (
        output allow_find_in, small_big_find_in, RdAddress_in,
        output sadResult_wire_1_in, sadResult_wire_2_in, sadResult_wire_3_in, sadResult_wire_4_in,
        output sadResult_wire_5_in, sadResult_wire_6_in, sadResult_wire_7_in, sadResult_wire_8_in,
        input  busy_out, stall_out, done_out, best_value_out, best_index_out,
        input  wr_en_out, wr_addr_out, wr_data_out
    );

    modport slave (
        input  allow_find_in, small_big_find_in, RdAddress_in,
        input  sadResult_wire_1_in, sadResult_wire_2_in, sadResult_wire_3_in, sadResult_wire_4_in,
        input  sadResult_wire_5_in, sadResult_wire_6_in, sadResult_wire_7_in, sadResult_wire_8_in,
        output busy_out, stall_out, done_out, best_value_out, best_index_out,
        output wr_en_out, wr_addr_out, wr_data_out
    );
endinterface

// File: rtl/wb_sad_minmax_finder.sv
// Writeback-stage iterative min/max finder over eight latched SAD results.
// One unsigned compare per cycle; a single register-file write in DONE.
module wb_sad_minmax_finder #(
    parameter int DATA_W  = 32,
    parameter int NUM_SAD = 8,
    parameter int ADDR_W  = 5
) (
    input logic                   clk,
    input logic                   rst,
    wb_sad_minmax_finder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SAD);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_sad [NUM_SAD];
    logic [DATA_W-1:0] w_sad_in [NUM_SAD];
    logic              r_mode;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_cnt;
    logic              w_busy;
    logic              w_done;
    logic              w_wr_en;
    logic              w_take;

    assign w_sad_in[0] = bus.sadResult_wire_1_in;
    assign w_sad_in[1] = bus.sadResult_wire_2_in;
    assign w_sad_in[2] = bus.sadResult_wire_3_in;
    assign w_sad_in[3] = bus.sadResult_wire_4_in;
    assign w_sad_in[4] = bus.sadResult_wire_5_in;
    assign w_sad_in[5] = bus.sadResult_wire_6_in;
    assign w_sad_in[6] = bus.sadResult_wire_7_in;
    assign w_sad_in[7] = bus.sadResult_wire_8_in;

    // Strict compare keeps the incumbent on ties, so the lowest index wins.
    assign w_take = r_mode ? (r_sad[r_cnt] > r_best) : (r_sad[r_cnt] < r_best);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            IDLE: if (bus.allow_find_in) w_next = SCAN;
            SCAN: begin
                w_busy = 1'b1;
                if (r_cnt == IDX_W'(NUM_SAD - 1)) w_next = DONE;
            end
            DONE: begin
                w_busy  = 1'b1;
                w_done  = 1'b1;
                w_wr_en = (r_rd != '0);   // x0 is hardwired, never written
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture at start, then one compare-and-replace per SCAN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SAD; i++) r_sad[i] <= '0;
            r_mode <= 1'b0;
            r_rd   <= '0;
            r_best <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.allow_find_in) begin
                    for (int i = 0; i < NUM_SAD; i++) r_sad[i] <= w_sad_in[i];
                    r_mode <= bus.small_big_find_in;
                    r_rd   <= bus.RdAddress_in;
                    r_best <= w_sad_in[0];
                    r_idx  <= '0;
                    r_cnt  <= IDX_W'(1);
                end
                SCAN: begin
                    if (w_take) begin
                        r_best <= r_sad[r_cnt];
                        r_idx  <= r_cnt;
                    end
                    r_cnt <= r_cnt + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out       = w_busy;
    assign bus.stall_out      = w_busy;
    assign bus.done_out       = w_done;
    assign bus.best_value_out = r_best;
    assign bus.best_index_out = 3'(r_idx);
    assign bus.wr_en_out      = w_wr_en;
    assign bus.wr_addr_out    = r_rd;
    assign bus.wr_data_out    = r_best;
endmodule

// File: tb/tb_wb_sad_minmax_finder.sv
// Self-checking bench for wb_sad_minmax_finder: directed scenarios plus
// randomized scans checked against a plain min/max-and-first-index model.
module tb_wb_sad_minmax_finder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] s   [8];
    logic [31:0] alt [8];

    wb_sad_minmax_finder_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_sad_minmax_finder #(.DATA_W(32), .NUM_SAD(8), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_sads(input logic [31:0] v [8]);
        bus.sadResult_wire_1_in = v[0];
        bus.sadResult_wire_2_in = v[1];
        bus.sadResult_wire_3_in = v[2];
        bus.sadResult_wire_4_in = v[3];
        bus.sadResult_wire_5_in = v[4];
        bus.sadResult_wire_6_in = v[5];
        bus.sadResult_wire_7_in = v[6];
        bus.sadResult_wire_8_in = v[7];
    endtask

    // Reference: extreme value first, then the lowest index holding it.
    task automatic model(input logic [31:0] v [8], input bit mode,
                         output logic [31:0] bv, output logic [2:0] bi);
        bv = v[0];
        for (int i = 1; i < 8; i++)
            if (mode ? (v[i] > bv) : (v[i] < bv)) bv = v[i];
        bi = 0;
        for (int i = 7; i >= 0; i--) if (v[i] == bv) bi = 3'(i);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},  {63'd0, bus.busy_out},  64'd0);
        chk({tag, ".stall"}, {63'd0, bus.stall_out}, 64'd0);
        chk({tag, ".done"},  {63'd0, bus.done_out},  64'd0);
        chk({tag, ".wren"},  {63'd0, bus.wr_en_out}, 64'd0);
        chk({tag, ".bval"},  {32'd0, bus.best_value_out}, 64'd0);
        chk({tag, ".bidx"},  {61'd0, bus.best_index_out}, 64'd0);
        chk({tag, ".waddr"}, {59'd0, bus.wr_addr_out}, 64'd0);
        chk({tag, ".wdata"}, {32'd0, bus.wr_data_out}, 64'd0);
    endtask

    // Start a scan on s[], then walk 9 cycles checking handshake and result.
    // If busy_hit is set, a second start with alt[] is attempted at cycle 3.
    task automatic run_scan(input string tag, input bit mode, input logic [4:0] rd,
                            input bit busy_hit);
        logic [31:0] ev;
        logic [2:0]  ei;
        int          dones;
        model(s, mode, ev, ei);
        @(negedge clk);
        drive_sads(s);
        bus.small_big_find_in = mode;
        bus.RdAddress_in      = rd;
        bus.allow_find_in     = 1'b1;
        @(posedge clk);                 // E0
        #1;
        bus.allow_find_in = 1'b0;
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (busy_hit) begin
                drive_sads(alt);
                bus.small_big_find_in = ~mode;
                bus.RdAddress_in      = ~rd;
                bus.allow_find_in     = (k == 3);
            end
            if (bus.done_out) dones++;
            chk($sformatf("%s.busy@%0d", tag, k), {63'd0, bus.busy_out}, {63'd0, k <= 8});
            chk($sformatf("%s.stall@%0d", tag, k), {63'd0, bus.stall_out}, {63'd0, k <= 8});
            chk($sformatf("%s.done@%0d", tag, k), {63'd0, bus.done_out}, {63'd0, k == 8});
            if (k == 8) begin
                chk({tag, ".bval"},  {32'd0, bus.best_value_out}, {32'd0, ev});
                chk({tag, ".bidx"},  {61'd0, bus.best_index_out}, {61'd0, ei});
                chk({tag, ".wren"},  {63'd0, bus.wr_en_out}, {63'd0, rd != 0});
                chk({tag, ".waddr"}, {59'd0, bus.wr_addr_out}, {59'd0, rd});
                chk({tag, ".wdata"}, {32'd0, bus.wr_data_out}, {32'd0, ev});
            end else begin
                chk($sformatf("%s.wren@%0d", tag, k), {63'd0, bus.wr_en_out}, 64'd0);
            end
        end
        bus.allow_find_in = 1'b0;
        if (busy_hit) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.done_out) dones++;
            end
            chk({tag, ".one_done"}, 64'(dones), 64'd1);
            chk({tag, ".idle"}, {63'd0, bus.busy_out}, 64'd0);
        end
        // Result holds in IDLE.
        chk({tag, ".hold"}, {32'd0, bus.best_value_out}, {32'd0, ev});
    endtask

    task automatic test_reset();
        bus.allow_find_in = 1'b0;
        bus.small_big_find_in = 1'b0;
        bus.RdAddress_in = '0;
        for (int i = 0; i < 8; i++) s[i] = 32'hDEAD_0000 + 32'(i);
        drive_sads(s);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");
    endtask

    task automatic test_min();
        s = '{40, 12, 99, 7, 55, 7, 300, 18};
        run_scan("min", 1'b0, 5'd5, 1'b0);
    endtask

    task automatic test_max();
        s = '{40, 12, 99, 7, 55, 7, 300, 18};
        run_scan("max", 1'b1, 5'd9, 1'b0);
    endtask

    task automatic test_ties();
        for (int i = 0; i < 8; i++) s[i] = 32'hFFFF_FFFF;
        run_scan("tie_ff", 1'b0, 5'd3, 1'b0);
        s = '{5, 0, 0, 0, 0, 0, 0, 0};
        run_scan("tie_5", 1'b1, 5'd17, 1'b0);
    endtask

    task automatic test_busy_start();
        s   = '{500, 400, 300, 200, 100, 50, 25, 60};
        alt = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_scan("busy", 1'b0, 5'd12, 1'b1);
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        s = '{9, 8, 7, 6, 5, 4, 3, 2};
        @(negedge clk);
        drive_sads(s);
        bus.small_big_find_in = 1'b1;
        bus.RdAddress_in      = 5'd21;
        bus.allow_find_in     = 1'b1;
        @(posedge clk);
        #1 bus.allow_find_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        wr_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wr_en_out || bus.done_out) wr_seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.wr_en_out || bus.done_out || bus.busy_out) wr_seen++;
        end
        chk("rst_mid.no_write", 64'(wr_seen), 64'd0);
        s = '{70, 71, 69, 72, 90, 69, 100, 3};
        run_scan("rst_fresh", 1'b0, 5'd30, 1'b0);
    endtask

    task automatic test_rd0();
        s = '{40, 12, 99, 7, 55, 7, 300, 18};
        run_scan("rd0", 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_back_to_back_random();
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 8; i++)
                s[i] = (r % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_scan($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_min();
        test_max();
        test_ties();
        test_busy_start();
        test_reset_mid();
        test_rd0();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
